// File: rtl/current_trip_ctrl.sv
// current_trip_ctrl: debounces the averaged-current over-threshold flag,
// removes load power on a confirmed overcurrent, waits a hold-off period,
// retries a bounded number of times and finally locks out until software
// clears the fault. All outputs are registered and decoded from next state.
module current_trip_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 1000000,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned STABLE_CYCLES   = 4000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        over_thld,
  input  logic        fault_clr,
  output logic        pwr_en,
  output logic        tripped,
  output logic        fault_latched,
  output logic [7:0]  retry_cnt,
  output logic [15:0] trip_total
);

  // Counters are wide enough to hold their terminal value so none can wrap.
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  // retry_cnt saturates at 255, so a larger limit behaves as 255.
  localparam logic [7:0] RETRY_MAX = 8'((MAX_RETRIES > 255) ? 255 : MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ON       = 2'd1,
    ST_OFF_WAIT = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [7:0]         retry_q, retry_d;
  logic [15:0]        trip_total_q, trip_total_d;
  logic               pwr_en_q, pwr_en_d;
  logic               tripped_q, tripped_d;
  logic               fault_q, fault_d;

  // Next-state, counter updates and next-state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    deb_d        = deb_q;
    hold_d       = hold_q;
    stab_d       = stab_q;
    retry_d      = retry_q;
    trip_total_d = trip_total_q;

    case (state_q)
      ST_LOCKOUT: begin
        // Only a software clear leaves lockout; enable and over_thld are ignored.
        if (fault_clr) begin
          state_d = ST_IDLE;
          retry_d = 8'd0;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end

      ST_IDLE: begin
        deb_d  = '0;
        hold_d = '0;
        stab_d = '0;
        if (enable) begin
          state_d = ST_ON;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ON: begin
        if (!enable) begin
          // Power request withdrawn wins over a simultaneous trip.
          state_d = ST_IDLE;
          deb_d   = '0;
          hold_d  = '0;
          stab_d  = '0;
        end else if (over_thld) begin
          stab_d = '0;
          if (deb_q == DEB_LAST) begin
            // Confirmed overcurrent on this edge.
            deb_d        = '0;
            trip_total_d = (trip_total_q != 16'hFFFF) ? (trip_total_q + 16'd1) : trip_total_q;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_LOCKOUT;
            end else begin
              state_d = ST_OFF_WAIT;
              hold_d  = '0;
              retry_d = (retry_q != 8'hFF) ? (retry_q + 8'd1) : retry_q;
            end
          end else begin
            deb_d = deb_q + DEB_ONE;
          end
        end else begin
          // A single low sample restarts debounce; clean time accumulates.
          deb_d = '0;
          if (stab_q == STAB_LAST) begin
            stab_d  = '0;
            retry_d = 8'd0;
          end else begin
            stab_d = stab_q + STAB_ONE;
          end
        end
      end

      ST_OFF_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          deb_d   = '0;
          hold_d  = '0;
          stab_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_ON;
          hold_d  = '0;
          deb_d   = '0;
          stab_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        deb_d   = '0;
        hold_d  = '0;
        stab_d  = '0;
      end
    endcase

    pwr_en_d  = (state_d == ST_ON);
    tripped_d = (state_d == ST_OFF_WAIT);
    fault_d   = (state_d == ST_LOCKOUT);
  end

  // State, counters and outputs; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      deb_q        <= '0;
      hold_q       <= '0;
      stab_q       <= '0;
      retry_q      <= 8'd0;
      trip_total_q <= 16'd0;
      pwr_en_q     <= 1'b0;
      tripped_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      deb_q        <= deb_d;
      hold_q       <= hold_d;
      stab_q       <= stab_d;
      retry_q      <= retry_d;
      trip_total_q <= trip_total_d;
      pwr_en_q     <= pwr_en_d;
      tripped_q    <= tripped_d;
      fault_q      <= fault_d;
    end
  end

  assign pwr_en        = pwr_en_q;
  assign tripped       = tripped_q;
  assign fault_latched = fault_q;
  assign retry_cnt     = retry_q;
  assign trip_total    = trip_total_q;

endmodule

// File: tb/tb_current_trip_ctrl.sv
// Testbench for current_trip_ctrl: directed scenario tasks with constant
// expectations, then randomized traffic compared against a behavioural model.
module tb_current_trip_ctrl;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 2;
  localparam int S = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        over_thld = 1'b0;
  logic        fault_clr = 1'b0;
  logic        pwr_en, tripped, fault_latched;
  logic [7:0]  retry_cnt;
  logic [15:0] trip_total;

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0 idle, 1 powered, 2 waiting, 3 locked.
  int m_mode = 0;
  int m_run = 0;
  int m_wait = 0;
  int m_clean = 0;
  int m_retry = 0;
  int m_trips = 0;

  current_trip_ctrl #(
    .DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .MAX_RETRIES(R), .STABLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .over_thld(over_thld),
    .fault_clr(fault_clr), .pwr_en(pwr_en), .tripped(tripped),
    .fault_latched(fault_latched), .retry_cnt(retry_cnt), .trip_total(trip_total)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    if (!reset_n) begin
      m_mode = 0; m_run = 0; m_wait = 0; m_clean = 0; m_retry = 0; m_trips = 0;
    end else if (m_mode == 3) begin
      if (fault_clr) begin
        m_mode = 0;
        m_retry = 0;
      end
    end else if (!enable) begin
      m_mode = 0; m_run = 0; m_wait = 0; m_clean = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_run = 0; m_clean = 0;
    end else if (m_mode == 1) begin
      if (over_thld) begin
        m_run++;
        m_clean = 0;
        if (m_run == D) begin
          m_run = 0;
          if (m_trips < 65535) m_trips++;
          if (m_retry == R) m_mode = 3;
          else begin
            if (m_retry < 255) m_retry++;
            m_mode = 2;
            m_wait = 0;
          end
        end
      end else begin
        m_run = 0;
        m_clean++;
        if (m_clean == S) begin
          m_clean = 0;
          m_retry = 0;
        end
      end
    end else begin
      m_wait++;
      if (m_wait == H) begin
        m_mode = 1; m_run = 0; m_clean = 0; m_wait = 0;
      end
    end
  endtask

  // One clock: update model, take the edge, settle 1 ns past it.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; over_thld = 1'b0; fault_clr = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1; over_thld = 1'b1; fault_clr = 1'b1;
    reset_n = 1'b0;
    cyc();
    checks++;
    if ({pwr_en, tripped, fault_latched, retry_cnt, trip_total} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pwr=%b trip=%b flt=%b retry=%0d total=%0d, want all 0",
               pwr_en, tripped, fault_latched, retry_cnt, trip_total);
    end
    reset_n = 1'b1; over_thld = 1'b0; fault_clr = 1'b0;
    cyc();
    checks++;
    if (pwr_en !== 1'b1 || tripped !== 1'b0 || fault_latched !== 1'b0 || trip_total !== 16'd0) begin
      errors++;
      $display("FAIL power_up: got pwr=%b trip=%b flt=%b total=%0d, want 1 0 0 0",
               pwr_en, tripped, fault_latched, trip_total);
    end
  endtask

  task automatic test_debounce_glitch();
    for (int i = 0; i < 7; i++) begin
      over_thld = (i == 3) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if (pwr_en !== 1'b1 || trip_total !== 16'd0) begin
        errors++;
        $display("FAIL glitch_no_trip[%0d]: got pwr=%b total=%0d, want 1 0", i, pwr_en, trip_total);
      end
    end
    over_thld = 1'b0;
    cyc();
  endtask

  task automatic test_trip_retry();
    over_thld = 1'b1;
    for (int i = 0; i < D - 1; i++) cyc();
    checks++;
    if (pwr_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_trip_pwr: got %b want 1", pwr_en);
    end
    cyc();
    checks++;
    if (pwr_en !== 1'b0 || tripped !== 1'b1 || trip_total !== 16'd1 || retry_cnt !== 8'd1) begin
      errors++;
      $display("FAIL trip1: got pwr=%b trip=%b total=%0d retry=%0d, want 0 1 1 1",
               pwr_en, tripped, trip_total, retry_cnt);
    end
    over_thld = 1'b0;
    for (int i = 0; i < H - 1; i++) cyc();
    checks++;
    if (tripped !== 1'b1 || pwr_en !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_hold: got pwr=%b trip=%b want 0 1", pwr_en, tripped);
    end
    cyc();
    checks++;
    if (pwr_en !== 1'b1 || tripped !== 1'b0) begin
      errors++;
      $display("FAIL retry_on: got pwr=%b trip=%b want 1 0", pwr_en, tripped);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    enable = 1'b1;
    cyc();
    over_thld = 1'b1;
    for (int t = 1; t <= R; t++) begin
      for (int i = 0; i < D; i++) cyc();
      checks++;
      if (tripped !== 1'b1 || retry_cnt !== 8'(t) || trip_total !== 16'(t)) begin
        errors++;
        $display("FAIL stuck_trip%0d: got trip=%b retry=%0d total=%0d", t, tripped, retry_cnt, trip_total);
      end
      for (int i = 0; i < H; i++) cyc();
    end
    for (int i = 0; i < D; i++) cyc();
    checks++;
    if (fault_latched !== 1'b1 || pwr_en !== 1'b0 || tripped !== 1'b0 || trip_total !== 16'd3) begin
      errors++;
      $display("FAIL lockout: got flt=%b pwr=%b trip=%b total=%0d, want 1 0 0 3",
               fault_latched, pwr_en, tripped, trip_total);
    end
    for (int i = 0; i < 6; i++) begin
      enable = i[0];
      cyc();
    end
    checks++;
    if (fault_latched !== 1'b1 || pwr_en !== 1'b0) begin
      errors++;
      $display("FAIL lockout_hold: got flt=%b pwr=%b want 1 0", fault_latched, pwr_en);
    end
    enable = 1'b1; over_thld = 1'b0; fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    checks++;
    if (fault_latched !== 1'b0 || pwr_en !== 1'b0 || retry_cnt !== 8'd0 || trip_total !== 16'd3) begin
      errors++;
      $display("FAIL fault_clr: got flt=%b pwr=%b retry=%0d total=%0d, want 0 0 0 3",
               fault_latched, pwr_en, retry_cnt, trip_total);
    end
    cyc();
    checks++;
    if (pwr_en !== 1'b1) begin
      errors++;
      $display("FAIL clr_then_on: got pwr=%b want 1", pwr_en);
    end
  endtask

  task automatic test_stable_clear();
    do_reset();
    enable = 1'b1;
    cyc();
    over_thld = 1'b1;
    for (int i = 0; i < D; i++) cyc();
    over_thld = 1'b0;
    for (int i = 0; i < H; i++) cyc();
    for (int i = 0; i < S - 1; i++) cyc();
    checks++;
    if (retry_cnt !== 8'd1 || pwr_en !== 1'b1) begin
      errors++;
      $display("FAIL stable_early: got retry=%0d pwr=%b want 1 1", retry_cnt, pwr_en);
    end
    cyc();
    checks++;
    if (retry_cnt !== 8'd0) begin
      errors++;
      $display("FAIL stable_clear: got retry=%0d want 0", retry_cnt);
    end
  endtask

  task automatic test_trip_edge_enable();
    do_reset();
    enable = 1'b1;
    cyc();
    over_thld = 1'b1;
    for (int i = 0; i < D - 1; i++) cyc();
    enable = 1'b0;
    cyc();
    checks++;
    if (pwr_en !== 1'b0 || tripped !== 1'b0 || fault_latched !== 1'b0 || trip_total !== 16'd0) begin
      errors++;
      $display("FAIL enable_on_trip_edge: got pwr=%b trip=%b flt=%b total=%0d, want 0 0 0 0",
               pwr_en, tripped, fault_latched, trip_total);
    end
    enable = 1'b1;
    cyc();
    for (int i = 0; i < D; i++) cyc();
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (tripped !== 1'b1) begin
      errors++;
      $display("FAIL mid_holdoff_setup: got trip=%b want 1", tripped);
    end
    reset_n = 1'b0;
    cyc();
    checks++;
    if ({pwr_en, tripped, fault_latched, retry_cnt, trip_total} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid_holdoff: got pwr=%b trip=%b flt=%b retry=%0d total=%0d, want all 0",
               pwr_en, tripped, fault_latched, retry_cnt, trip_total);
    end
    reset_n = 1'b1; over_thld = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      reset_n   = ($urandom_range(0, 999) != 0);
      enable    = ($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0;
      fault_clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 5) == 0) over_thld = ~over_thld;
      cyc();
      checks++;
      if (pwr_en !== (m_mode == 1) || tripped !== (m_mode == 2) || fault_latched !== (m_mode == 3) ||
          retry_cnt !== 8'(m_retry) || trip_total !== 16'(m_trips)) begin
        errors++;
        $display("FAIL random[%0d]: got pwr=%b trip=%b flt=%b retry=%0d total=%0d, want mode=%0d retry=%0d total=%0d",
                 n, pwr_en, tripped, fault_latched, retry_cnt, trip_total, m_mode, m_retry, m_trips);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_glitch();
    test_trip_retry();
    test_lockout();
    test_stable_clear();
    test_trip_edge_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
